// File: rtl/qa_shim_mdata_rob_if.sv
// Bundle of allocation, response and dequeue signals for the Mdata reorder shim.
// The slave modport is the shim's view; the master modport is the client/QLP view.
interface qa_shim_mdata_rob_if #(
  parameter int N_ENTRIES   = 128,
  parameter int N_DATA_BITS = 512,
  parameter int N_META_BITS = 13
);
  localparam int IDX_W = $clog2(N_ENTRIES);

  logic                   alloc_req;
  logic [N_META_BITS-1:0] alloc_meta;
  logic                   alloc_rdy;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   rsp_valid;
  logic [IDX_W-1:0]       rsp_idx;
  logic [N_DATA_BITS-1:0] rsp_data;
  logic                   deq_valid;
  logic [N_META_BITS-1:0] deq_meta;
  logic [N_DATA_BITS-1:0] deq_data;
  logic                   deq_en;
  logic [IDX_W:0]         occupancy;
  logic                   error;

  modport master (
    output alloc_req, alloc_meta, rsp_valid, rsp_idx, rsp_data, deq_en,
    input  alloc_rdy, alloc_idx, deq_valid, deq_meta, deq_data, occupancy, error
  );

  modport slave (
    input  alloc_req, alloc_meta, rsp_valid, rsp_idx, rsp_data, deq_en,
    output alloc_rdy, alloc_idx, deq_valid, deq_meta, deq_data, occupancy, error
  );
endinterface

// File: rtl/qa_shim_mdata_rob.sv
// Reorder buffer returning out-of-order read responses in allocation order, with saved client Mdata.
// Define QA_SHIM_MDATA_ROB_CHECK_EN to enable sticky protocol-error detection on responses/allocations.
module qa_shim_mdata_rob #(
  parameter int N_ENTRIES   = 128,
  parameter int N_DATA_BITS = 512,
  parameter int N_META_BITS = 13
) (
  input  logic               clk,
  input  logic               reset,
  qa_shim_mdata_rob_if.slave rob
);
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_ENTRIES);

  logic [IDX_W-1:0]       tail_q, tail_d;
  logic [IDX_W-1:0]       head_q, head_d;
  logic [IDX_W-1:0]       rd_ptr_s;
  logic [CNT_W-1:0]       occ_q, occ_d;
  logic                   alloc_rdy_q, alloc_rdy_d;
  logic                   deq_valid_q, deq_valid_d;
  logic [N_ENTRIES-1:0]   filled_q, filled_d;
  logic                   error_q, error_d;
  logic                   alloc_acc_s;
  logic                   deq_acc_s;
  logic                   rsp_wr_s;
  logic                   pending_s;
  logic                   load_s;

  logic [N_DATA_BITS-1:0] ram_q  [N_ENTRIES];
  logic [N_META_BITS-1:0] meta_q [N_ENTRIES];
  logic [N_DATA_BITS-1:0] deq_data_q;
  logic [N_META_BITS-1:0] deq_meta_q;

  // Handshake qualification and output-stage load decision.
  // rd_ptr_s is the oldest slot not yet in the output stage (head+1 while one is presented).
  always_comb begin
    alloc_acc_s = rob.alloc_req & alloc_rdy_q;
    deq_acc_s   = rob.deq_en & deq_valid_q;
    rd_ptr_s    = head_q + IDX_W'(deq_valid_q);
    pending_s   = (occ_q > CNT_W'(deq_valid_q));
    load_s      = (~deq_valid_q | rob.deq_en) & pending_s & filled_q[rd_ptr_s];
  end

`ifdef QA_SHIM_MDATA_ROB_CHECK_EN
  logic [IDX_W-1:0] rsp_off_s;
  logic             rsp_alloc_s;
  logic             rsp_bad_s;

  // Response legality: index must lie in [head, head+occupancy) and not already be filled.
  always_comb begin
    rsp_off_s   = rob.rsp_idx - head_q;
    rsp_alloc_s = (CNT_W'(rsp_off_s) < occ_q);
    rsp_bad_s   = rob.rsp_valid & (~rsp_alloc_s | filled_q[rob.rsp_idx]);
    rsp_wr_s    = rob.rsp_valid & ~rsp_bad_s;
    error_d     = error_q | rsp_bad_s | (rob.alloc_req & ~alloc_rdy_q);
  end
`else
  // Unchecked build: every response is written and the error flag stays low.
  always_comb begin
    rsp_wr_s = rob.rsp_valid;
    error_d  = 1'b0;
  end
`endif

  // Next-state for pointers, occupancy, filled bits and the output-stage valid.
  always_comb begin
    tail_d      = alloc_acc_s ? (tail_q + IDX_W'(1)) : tail_q;
    head_d      = deq_acc_s ? (head_q + IDX_W'(1)) : head_q;
    occ_d       = occ_q + CNT_W'(alloc_acc_s) - CNT_W'(deq_acc_s);
    alloc_rdy_d = (occ_d < FULL_CNT);
    filled_d    = filled_q;
    // Allocation clears after the response set, so a same-index collision leaves the slot empty.
    filled_d[rob.rsp_idx] = filled_q[rob.rsp_idx] | rsp_wr_s;
    filled_d[tail_q]      = filled_d[tail_q] & ~alloc_acc_s;
    if (load_s) begin
      deq_valid_d = 1'b1;
    end else if (deq_acc_s) begin
      deq_valid_d = 1'b0;
    end else begin
      deq_valid_d = deq_valid_q;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tail_q      <= '0;
      head_q      <= '0;
      occ_q       <= '0;
      alloc_rdy_q <= 1'b1;
      deq_valid_q <= 1'b0;
      filled_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      tail_q      <= tail_d;
      head_q      <= head_d;
      occ_q       <= occ_d;
      alloc_rdy_q <= alloc_rdy_d;
      deq_valid_q <= deq_valid_d;
      filled_q    <= filled_d;
      error_q     <= error_d;
    end
  end

  // Payload/Mdata storage and registered read port; contents need no reset.
  always_ff @(posedge clk) begin
    if (rsp_wr_s) begin
      ram_q[rob.rsp_idx] <= rob.rsp_data;
    end
    if (alloc_acc_s) begin
      meta_q[tail_q] <= rob.alloc_meta;
    end
    if (load_s) begin
      deq_data_q <= ram_q[rd_ptr_s];
      deq_meta_q <= meta_q[rd_ptr_s];
    end
  end

  assign rob.alloc_rdy = alloc_rdy_q;
  assign rob.alloc_idx = tail_q;
  assign rob.deq_valid = deq_valid_q;
  assign rob.deq_meta  = deq_meta_q;
  assign rob.deq_data  = deq_data_q;
  assign rob.occupancy = occ_q;
  assign rob.error     = error_q;
endmodule

// File: tb/tb_qa_shim_mdata_rob.sv
// Directed bench for qa_shim_mdata_rob: a 4-slot instance for ordering/full/reset/error cases
// and an 8-slot instance for head latency and back-to-back dequeue.
module tb_qa_shim_mdata_rob;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

`ifdef QA_SHIM_MDATA_ROB_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  qa_shim_mdata_rob_if #(.N_ENTRIES(4), .N_DATA_BITS(32), .N_META_BITS(8)) i4 ();
  qa_shim_mdata_rob_if #(.N_ENTRIES(8), .N_DATA_BITS(32), .N_META_BITS(8)) i8 ();

  qa_shim_mdata_rob #(.N_ENTRIES(4), .N_DATA_BITS(32), .N_META_BITS(8)) dut4 (
    .clk(clk), .reset(reset), .rob(i4.slave)
  );
  qa_shim_mdata_rob #(.N_ENTRIES(8), .N_DATA_BITS(32), .N_META_BITS(8)) dut8 (
    .clk(clk), .reset(reset), .rob(i8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv4(input logic ar, input logic [7:0] am, input logic rv,
                      input logic [1:0] ri, input logic [31:0] rd, input logic de);
    i4.alloc_req  = ar;
    i4.alloc_meta = am;
    i4.rsp_valid  = rv;
    i4.rsp_idx    = ri;
    i4.rsp_data   = rd;
    i4.deq_en     = de;
  endtask

  task automatic drv8(input logic ar, input logic [7:0] am, input logic rv,
                      input logic [2:0] ri, input logic [31:0] rd, input logic de);
    i8.alloc_req  = ar;
    i8.alloc_meta = am;
    i8.rsp_valid  = rv;
    i8.rsp_idx    = ri;
    i8.rsp_data   = rd;
    i8.deq_en     = de;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0);
    drv8(1'b0, 8'h00, 1'b0, 3'd0, 32'h0, 1'b0);
    tick();
    tick();
    chk("rst_dv4",   64'(i4.deq_valid), 64'd0);
    chk("rst_rdy4",  64'(i4.alloc_rdy), 64'd1);
    chk("rst_idx4",  64'(i4.alloc_idx), 64'd0);
    chk("rst_occ4",  64'(i4.occupancy), 64'd0);
    chk("rst_err4",  64'(i4.error),     64'd0);
    chk("rst_dv8",   64'(i8.deq_valid), 64'd0);
    reset = 1'b0;

    // Out-of-order responses 2,0,1 must drain as A,B,C
    drv4(1'b1, 8'h0A, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    chk("a_idx1", 64'(i4.alloc_idx), 64'd1);
    chk("a_occ1", 64'(i4.occupancy), 64'd1);
    drv4(1'b1, 8'h0B, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    drv4(1'b1, 8'h0C, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    chk("a_idx3", 64'(i4.alloc_idx), 64'd3);
    chk("a_occ3", 64'(i4.occupancy), 64'd3);
    drv4(1'b0, 8'h00, 1'b1, 2'd2, 32'hC0C0_0002, 1'b0); tick();
    chk("a_dv_r2", 64'(i4.deq_valid), 64'd0);
    drv4(1'b0, 8'h00, 1'b1, 2'd0, 32'hA0A0_0000, 1'b0); tick();
    chk("a_dv_r0", 64'(i4.deq_valid), 64'd0);
    drv4(1'b0, 8'h00, 1'b1, 2'd1, 32'hB0B0_0001, 1'b0); tick();
    chk("a_dv_A",   64'(i4.deq_valid), 64'd1);
    chk("a_meta_A", 64'(i4.deq_meta),  64'h0A);
    chk("a_data_A", 64'(i4.deq_data),  64'hA0A0_0000);
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b1); tick();
    chk("a_meta_B", 64'(i4.deq_meta),  64'h0B);
    chk("a_data_B", 64'(i4.deq_data),  64'hB0B0_0001);
    chk("a_occ_B",  64'(i4.occupancy), 64'd2);
    tick();
    chk("a_meta_C", 64'(i4.deq_meta),  64'h0C);
    chk("a_data_C", 64'(i4.deq_data),  64'hC0C0_0002);
    tick();
    chk("a_dv_end",  64'(i4.deq_valid), 64'd0);
    chk("a_occ_end", 64'(i4.occupancy), 64'd0);

    // Asynchronous reset with three slots outstanding
    drv4(1'b1, 8'h31, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    drv4(1'b1, 8'h32, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    drv4(1'b1, 8'h33, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    chk("r_occ3", 64'(i4.occupancy), 64'd3);
    drv4(1'b0, 8'h00, 1'b1, 2'd3, 32'h0000_3333, 1'b0); tick();
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    chk("r_dv_pre",   64'(i4.deq_valid), 64'd1);
    chk("r_meta_pre", 64'(i4.deq_meta),  64'h31);
    #3 reset = 1'b1;
    #1;
    chk("r_dv0",   64'(i4.deq_valid), 64'd0);
    chk("r_occ0",  64'(i4.occupancy), 64'd0);
    chk("r_idx0",  64'(i4.alloc_idx), 64'd0);
    chk("r_rdy1",  64'(i4.alloc_rdy), 64'd1);
    tick();
    reset = 1'b0;

    // Fill all four slots, attempt an overflow, then free one
    for (int i = 0; i < 4; i++) begin
      drv4(1'b1, 8'(8'h10 + i), 1'b0, 2'd0, 32'h0, 1'b0);
      tick();
    end
    chk("f_occ4", 64'(i4.occupancy), 64'd4);
    chk("f_rdy0", 64'(i4.alloc_rdy), 64'd0);
    chk("f_idx0", 64'(i4.alloc_idx), 64'd0);
    drv4(1'b1, 8'h1F, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    chk("f_ovf_occ", 64'(i4.occupancy), 64'd4);
    chk("f_ovf_idx", 64'(i4.alloc_idx), 64'd0);
    chk("f_ovf_err", 64'(i4.error),     64'(ERR_EXP));
    drv4(1'b0, 8'h00, 1'b1, 2'd0, 32'hD000_0000, 1'b0); tick();
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    chk("f_dv",   64'(i4.deq_valid), 64'd1);
    chk("f_meta", 64'(i4.deq_meta),  64'h10);
    chk("f_data", 64'(i4.deq_data),  64'hD000_0000);
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b1); tick();
    chk("f_occ3",  64'(i4.occupancy), 64'd3);
    chk("f_rdy1",  64'(i4.alloc_rdy), 64'd1);
    chk("f_idxw",  64'(i4.alloc_idx), 64'd0);
    chk("f_dv0",   64'(i4.deq_valid), 64'd0);

    // Simultaneous allocate and dequeue at occupancy 2
    drv4(1'b0, 8'h00, 1'b1, 2'd1, 32'h0000_D111, 1'b0); tick();
    drv4(1'b0, 8'h00, 1'b1, 2'd2, 32'h0000_D222, 1'b0); tick();
    chk("s_meta1", 64'(i4.deq_meta), 64'h11);
    drv4(1'b0, 8'h00, 1'b1, 2'd3, 32'h0000_D333, 1'b0); tick();
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b1); tick();
    chk("s_occ2a", 64'(i4.occupancy), 64'd2);
    chk("s_data2", 64'(i4.deq_data),  64'h0000_D222);
    drv4(1'b1, 8'h14, 1'b0, 2'd0, 32'h0, 1'b1); tick();
    chk("s_occ2b", 64'(i4.occupancy), 64'd2);
    chk("s_meta3", 64'(i4.deq_meta),  64'h13);
    chk("s_data3", 64'(i4.deq_data),  64'h0000_D333);
    chk("s_idx1",  64'(i4.alloc_idx), 64'd1);
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b1); tick();
    chk("s_dv0",   64'(i4.deq_valid), 64'd0);
    chk("s_occ1",  64'(i4.occupancy), 64'd1);
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0);

    // Response to an unallocated slot
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("e_err_rst", 64'(i4.error), 64'd0);
    drv4(1'b1, 8'h14, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    chk("e_idx1", 64'(i4.alloc_idx), 64'd1);
    drv4(1'b0, 8'h00, 1'b1, 2'd3, 32'hBAD0_0003, 1'b0); tick();
    chk("e_err1", 64'(i4.error), 64'(ERR_EXP));
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    chk("e_err2", 64'(i4.error), 64'(ERR_EXP));
    drv4(1'b0, 8'h00, 1'b1, 2'd0, 32'hE000_0000, 1'b0); tick();
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0); tick();
    chk("e_dv",   64'(i4.deq_valid), 64'd1);
    chk("e_meta", 64'(i4.deq_meta),  64'h14);
    chk("e_data", 64'(i4.deq_data),  64'hE000_0000);
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b1); tick();
    chk("e_dv0",  64'(i4.deq_valid), 64'd0);
    chk("e_occ0", 64'(i4.occupancy), 64'd0);
    chk("e_err3", 64'(i4.error),     64'(ERR_EXP));
    drv4(1'b0, 8'h00, 1'b0, 2'd0, 32'h0, 1'b0);

    // Head latency t+2 and eight back-to-back dequeues on the 8-slot instance
    for (int i = 0; i < 8; i++) begin
      drv8(1'b1, 8'(8'h20 + i), 1'b0, 3'd0, 32'h0, 1'b0);
      tick();
    end
    chk("h_occ8", 64'(i8.occupancy), 64'd8);
    chk("h_rdy0", 64'(i8.alloc_rdy), 64'd0);
    for (int i = 1; i < 8; i++) begin
      drv8(1'b0, 8'h00, 1'b1, 3'(i), 32'(32'h8000 + i), 1'b1);
      tick();
    end
    chk("h_dv_nohead", 64'(i8.deq_valid), 64'd0);
    drv8(1'b0, 8'h00, 1'b1, 3'd0, 32'h0000_8000, 1'b1); tick();
    chk("h_dv_t1", 64'(i8.deq_valid), 64'd0);
    drv8(1'b0, 8'h00, 1'b0, 3'd0, 32'h0, 1'b1); tick();
    chk("h_dv_t2",  64'(i8.deq_valid), 64'd1);
    chk("h_meta_0", 64'(i8.deq_meta),  64'h20);
    chk("h_data_0", 64'(i8.deq_data),  64'h8000);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("h_dv_n",   64'(i8.deq_valid), 64'd1);
      chk("h_meta_n", 64'(i8.deq_meta),  64'(8'h20 + i));
      chk("h_data_n", 64'(i8.deq_data),  64'(32'h8000 + i));
    end
    tick();
    chk("h_dv_end",  64'(i8.deq_valid), 64'd0);
    chk("h_occ_end", 64'(i8.occupancy), 64'd0);
    chk("h_rdy_end", 64'(i8.alloc_rdy), 64'd1);
    drv8(1'b0, 8'h00, 1'b0, 3'd0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
